// File: rtl/seq_serializer.sv
// Parallel-to-serial frame shifter, MSB first, DIV clocks per bit, optional
// back-to-back repetition of the held frame.
module seq_serializer #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DIV   = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] pattern,
  input  logic             start,
  input  logic             repeat_frame,
  output logic             seq_out,
  output logic             bit_strobe,
  output logic             busy,
  output logic             done
);

  localparam int unsigned BIT_W = $clog2(WIDTH) + 1;
  localparam int unsigned DIV_W = $clog2(DIV) + 1;
  localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(WIDTH - 1);
  localparam logic [DIV_W-1:0] LAST_DIV = DIV_W'(DIV - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] shift_q, shift_d;
  logic [WIDTH-1:0] hold_q, hold_d;
  logic [BIT_W-1:0] bit_cnt_q, bit_cnt_d;
  logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
  logic             seq_out_q, seq_out_d;
  logic             bit_strobe_q, bit_strobe_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  // State, datapath and output registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      shift_q      <= '0;
      hold_q       <= '0;
      bit_cnt_q    <= '0;
      div_cnt_q    <= '0;
      seq_out_q    <= 1'b0;
      bit_strobe_q <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      shift_q      <= shift_d;
      hold_q       <= hold_d;
      bit_cnt_q    <= bit_cnt_d;
      div_cnt_q    <= div_cnt_d;
      seq_out_q    <= seq_out_d;
      bit_strobe_q <= bit_strobe_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
    end
  end

  // Next-state and datapath update
  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    hold_d    = hold_q;
    bit_cnt_d = bit_cnt_q;
    div_cnt_d = div_cnt_q;

    case (state_q)
      ST_IDLE, ST_DONE: begin
        state_d = ST_IDLE;
        if (start) begin
          state_d   = ST_SHIFT;
          shift_d   = pattern;
          hold_d    = pattern;
          bit_cnt_d = '0;
          div_cnt_d = '0;
        end
      end
      ST_SHIFT: begin
        if (div_cnt_q == LAST_DIV) begin
          div_cnt_d = '0;
          shift_d   = {shift_q[WIDTH-2:0], 1'b0};
          if (bit_cnt_q == LAST_BIT) begin
            // repeat is only looked at on the final strobe of a frame
            bit_cnt_d = '0;
            if (repeat_frame) begin
              shift_d = hold_q;
            end else begin
              state_d = ST_DONE;
            end
          end else begin
            bit_cnt_d = bit_cnt_q + BIT_W'(1);
          end
        end else begin
          div_cnt_d = div_cnt_q + DIV_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Outputs are precomputed from next state so they leave flops directly
  always_comb begin
    seq_out_d    = 1'b0;
    bit_strobe_d = 1'b0;
    busy_d       = 1'b0;
    done_d       = 1'b0;
    if (state_d == ST_SHIFT) begin
      seq_out_d    = shift_d[WIDTH-1];
      bit_strobe_d = (div_cnt_d == LAST_DIV);
      busy_d       = 1'b1;
    end
    if (state_d == ST_DONE) begin
      done_d = 1'b1;
    end
  end

  assign seq_out    = seq_out_q;
  assign bit_strobe = bit_strobe_q;
  assign busy       = busy_q;
  assign done       = done_q;

endmodule
